fwd_hazard_ctrl: RTL and testbench

- Forwarding and hazard controller for the 5-stage integer pipeline.
- Tracks the destination registers of in-flight instructions in EX, MEM and WB.
- Generates registered 2-bit selects for the two 4:1 operand muxes in front of the ALU.
- Raises a load-use stall and inserts EX bubbles on stall or flush. Sits alongside the ID/EX pipeline register.

---
 rtl/fwd_hazard_ctrl.sv | 154 +++++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for a 5-stage integer pipeline.
// Optional perf counters (stall_count, fwd_count) are enabled by FWD_HAZARD_PERF_EN.
module fwd_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  input  logic                  mem_stall,
  output logic                  hazard_stall,
  output logic [1:0]            sel_a,
  output logic [1:0]            sel_b,
  output logic                  ex_valid
`ifdef FWD_HAZARD_PERF_EN
  ,
  output logic [31:0]           stall_count,
  output logic [31:0]           fwd_count
`endif
);

  // Tracking entries; only the EX entry needs its load flag, since a load
  // that has reached MEM or WB forwards like any other producer.
  logic                  r_ex_valid;
  logic [REG_ADDR_W-1:0] r_ex_rd;
  logic                  r_ex_we;
  logic                  r_ex_load;
  logic                  r_mem_valid;
  logic [REG_ADDR_W-1:0] r_mem_rd;
  logic                  r_mem_we;
  logic                  r_wb_valid;
  logic [REG_ADDR_W-1:0] r_wb_rd;
  logic                  r_wb_we;
  logic [1:0]            r_sel_a;
  logic [1:0]            r_sel_b;

  logic                  w_ex_a;
  logic                  w_ex_b;
  logic                  w_mem_a;
  logic                  w_mem_b;
  logic                  w_wb_a;
  logic                  w_wb_b;
  logic [1:0]            w_sel_a;
  logic [1:0]            w_sel_b;
  logic                  w_stall;
  logic                  w_issue;

  function automatic logic f_match(input logic v, input logic we,
                                   input logic [REG_ADDR_W-1:0] rd,
                                   input logic [REG_ADDR_W-1:0] src,
                                   input logic use_s);
    logic zero_ok;
    zero_ok = (ZERO_REG == 1'b0) || (src != {REG_ADDR_W{1'b0}});
    return v & we & (rd == src) & use_s & zero_ok;
  endfunction

  function automatic logic [1:0] f_sel(input logic m_ex, input logic m_mem,
                                       input logic m_wb);
    logic [1:0] sel;
    if (m_ex) begin
      sel = 2'b01;
    end else if (m_mem) begin
      sel = 2'b10;
    end else if (m_wb) begin
      sel = 2'b11;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Source matching, select priority and load-use detection.
  always_comb begin
    w_ex_a  = f_match(r_ex_valid,  r_ex_we,  r_ex_rd,  id_rs1, id_use_rs1);
    w_ex_b  = f_match(r_ex_valid,  r_ex_we,  r_ex_rd,  id_rs2, id_use_rs2);
    w_mem_a = f_match(r_mem_valid, r_mem_we, r_mem_rd, id_rs1, id_use_rs1);
    w_mem_b = f_match(r_mem_valid, r_mem_we, r_mem_rd, id_rs2, id_use_rs2);
    w_wb_a  = f_match(r_wb_valid,  r_wb_we,  r_wb_rd,  id_rs1, id_use_rs1);
    w_wb_b  = f_match(r_wb_valid,  r_wb_we,  r_wb_rd,  id_rs2, id_use_rs2);
    w_sel_a = f_sel(w_ex_a, w_mem_a, w_wb_a);
    w_sel_b = f_sel(w_ex_b, w_mem_b, w_wb_b);
    w_stall = id_valid & ~flush & r_ex_load & (w_ex_a | w_ex_b);
    w_issue = id_valid & ~flush & ~w_stall;
  end

  assign hazard_stall = w_stall;
  assign sel_a        = r_sel_a;
  assign sel_b        = r_sel_b;
  assign ex_valid     = r_ex_valid;

  // Pipeline tracking advance; a bubble keeps the stale index fields but is invalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex_valid  <= 1'b0;
      r_ex_rd     <= {REG_ADDR_W{1'b0}};
      r_ex_we     <= 1'b0;
      r_ex_load   <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_rd    <= {REG_ADDR_W{1'b0}};
      r_mem_we    <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_wb_rd     <= {REG_ADDR_W{1'b0}};
      r_wb_we     <= 1'b0;
      r_sel_a     <= 2'b00;
      r_sel_b     <= 2'b00;
    end else if (!mem_stall) begin
      r_wb_valid  <= r_mem_valid;
      r_wb_rd     <= r_mem_rd;
      r_wb_we     <= r_mem_we;
      r_mem_valid <= r_ex_valid;
      r_mem_rd    <= r_ex_rd;
      r_mem_we    <= r_ex_we;
      r_ex_valid  <= w_issue;
      r_ex_rd     <= id_rd;
      r_ex_we     <= id_reg_write;
      r_ex_load   <= id_mem_read & w_issue;
      r_sel_a     <= w_issue ? w_sel_a : 2'b00;
      r_sel_b     <= w_issue ? w_sel_b : 2'b00;
    end
  end

`ifdef FWD_HAZARD_PERF_EN
  logic [31:0] r_stall_count;
  logic [31:0] r_fwd_count;

  // Saturating performance counters, frozen together with the pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_count <= 32'd0;
      r_fwd_count   <= 32'd0;
    end else if (!mem_stall) begin
      if (w_stall && (r_stall_count != 32'hFFFF_FFFF)) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
      if (w_issue && ((w_sel_a != 2'b00) || (w_sel_b != 2'b00)) &&
          (r_fwd_count != 32'hFFFF_FFFF)) begin
        r_fwd_count <= r_fwd_count + 32'd1;
      end
    end
  end

  assign stall_count = r_stall_count;
  assign fwd_count   = r_fwd_count;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed self-checking bench for fwd_hazard_ctrl.
module tb_fwd_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic [4:0] id_rd;
  logic       id_reg_write;
  logic       id_mem_read;
  logic       flush;
  logic       mem_stall;
  logic       hazard_stall;
  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic       ex_valid;
`ifdef FWD_HAZARD_PERF_EN
  logic [31:0] stall_count;
  logic [31:0] fwd_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  fwd_hazard_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .mem_stall    (mem_stall),
    .hazard_stall (hazard_stall),
    .sel_a        (sel_a),
    .sel_b        (sel_b),
    .ex_valid     (ex_valid)
`ifdef FWD_HAZARD_PERF_EN
    ,
    .stall_count  (stall_count),
    .fwd_count    (fwd_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Present an instruction in ID: valid, rs1, rs2, use1, use2, rd, reg_write, mem_read.
  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic we, input logic ld);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_reg_write = we; id_mem_read = ld;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop_drain();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    repeat (3) tick();
  endtask

  task automatic check_ex(input string tag, input logic [1:0] ea, input logic [1:0] eb,
                          input logic ev);
    check({tag, "_sel_a"}, {30'd0, sel_a}, {30'd0, ea});
    check({tag, "_sel_b"}, {30'd0, sel_b}, {30'd0, eb});
    check({tag, "_ex_valid"}, {31'd0, ex_valid}, {31'd0, ev});
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; mem_stall = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    check_ex("reset", 2'b00, 2'b00, 1'b0);
    check("reset_stall", {31'd0, hazard_stall}, 32'd0);
    reset = 1'b0;
    tick();

    // distance-1 forward to operand A
    set_id(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0);
    tick();
    check_ex("prod_r3", 2'b00, 2'b00, 1'b1);
    set_id(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    check_ex("dist1", 2'b01, 2'b00, 1'b1);
    nop_drain();

    // r7 consumed at distances 2, 3, 4
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    tick();
    check_ex("dist2", 2'b00, 2'b10, 1'b1);
    tick();
    check_ex("dist3", 2'b00, 2'b11, 1'b1);
    tick();
    check_ex("dist4", 2'b00, 2'b00, 1'b1);
    nop_drain();

    // youngest writer of r4 wins
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0);
    tick();
    tick();
    set_id(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    check_ex("youngest", 2'b01, 2'b00, 1'b1);
    nop_drain();

    // load-use on r5
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    check("lu_stall", {31'd0, hazard_stall}, 32'd1);
    tick();
    check_ex("lu_bubble", 2'b00, 2'b00, 1'b0);
    check("lu_stall_gone", {31'd0, hazard_stall}, 32'd0);
    tick();
    check_ex("lu_fwd", 2'b00, 2'b10, 1'b1);
    nop_drain();

    // register 0 never forwards or stalls
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    check("zero_stall", {31'd0, hazard_stall}, 32'd0);
    tick();
    check_ex("zero_fwd", 2'b00, 2'b00, 1'b1);
    nop_drain();

    // flush beats load-use; stale rd of the bubble must not match
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b1);
    tick();
    flush = 1'b1;
    set_id(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0);
    check("flush_stall", {31'd0, hazard_stall}, 32'd0);
    tick();
    flush = 1'b0;
    check_ex("flush_bubble", 2'b00, 2'b00, 1'b0);
    set_id(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    check_ex("stale_rd", 2'b00, 2'b00, 1'b1);
    nop_drain();

    // independent selects from different stages
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd12, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd13, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd12, 5'd13, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    tick();
    check_ex("both_ops", 2'b10, 2'b01, 1'b1);
    nop_drain();

    // mem_stall freezes selects and ex_valid
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    check_ex("pre_freeze", 2'b01, 2'b00, 1'b1);
    mem_stall = 1'b1;
    set_id(1'b1, 5'd0, 5'd8, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_ex("freeze", 2'b01, 2'b00, 1'b1);
    end
    mem_stall = 1'b0;
    tick();
    check_ex("unfreeze", 2'b00, 2'b10, 1'b1);
    nop_drain();

    // asynchronous reset mid-sequence
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd11, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd11, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    check("pre_rst_stall", {31'd0, hazard_stall}, 32'd1);
    check_ex("pre_rst", 2'b00, 2'b00, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_ex("async_rst", 2'b00, 2'b00, 1'b0);
    check("async_rst_stall", {31'd0, hazard_stall}, 32'd0);
    #1;
    reset = 1'b0;
    tick();
    check_ex("post_rst", 2'b00, 2'b00, 1'b1);

`ifdef FWD_HAZARD_PERF_EN
    check("perf_stall_cnt", stall_count, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
